// File: rtl/system_cpu_0_mul_pkg.sv
// Shared definitions for the CPU multiply sequencer: op encodings, FSM
// states and the partial-product shift table.
package system_cpu_0_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
  localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULXSS = 2'd3;

  // ST_FAST is only reachable when the single-pass MUL path is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FAST,
    ST_DRAIN,
    ST_CORRECT,
    ST_DONE
  } mul_state_t;

  // Left shift applied to partial product k: Al*Bl, Ah*Bl, Al*Bh, Ah*Bh.
  localparam logic [5:0] PP_SHIFT [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

  // Zero-extended 16-bit half of a 32-bit operand.
  function automatic logic [31:0] pp_half(input logic [31:0] v, input logic hi);
    return hi ? {16'h0, v[31:16]} : {16'h0, v[15:0]};
  endfunction

endpackage

// File: rtl/system_cpu_0_mulx_acc.sv
// 64-bit partial-product accumulator with signed high-word correction and
// MUL/MULX result word selection. Pure datapath; sequencing is external.
module system_cpu_0_mulx_acc
  import system_cpu_0_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        add,
  input  logic [1:0]  add_idx,
  input  logic [31:0] add_value,
  input  logic        correct,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        load,
  output logic [31:0] result
);

  logic [63:0] acc_q;
  logic [31:0] res_q;
  logic [31:0] corr;
  logic [31:0] sel;

  // Signed correction term subtracted from the unsigned high word.
  always_comb begin
    corr = '0;
    case (op)
      MUL_OP_MULXSS: corr = (opa[31] ? opb : '0) + (opb[31] ? opa : '0);
      MUL_OP_MULXSU: corr = opa[31] ? opb : '0;
      default:       corr = '0;
    endcase
  end

  assign sel = (op == MUL_OP_MUL) ? acc_q[31:0] : acc_q[63:32];

  // Accumulator: clear on accept, add shifted partial products, then correct.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (add) begin
      acc_q <= acc_q + ({32'h0, add_value} << PP_SHIFT[add_idx]);
    end else if (correct) begin
      acc_q[63:32] <= acc_q[63:32] - corr;
    end
  end

  // Result holding register, refreshed on each done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
    end else if (load) begin
      res_q <= sel;
    end
  end

  // The new word is visible in the done cycle itself, then held.
  assign result = load ? sel : res_q;

endmodule

// File: rtl/system_cpu_0_mulx_seq.sv
// Multi-cycle multiply sequencer feeding the 32x32 (low-word) multiply cell.
// Issues four 16x16 partial products, accumulates, corrects for signedness.
// Optional: SYSTEM_CPU_0_MULX_FAST_MUL_EN sends MUL through the cell in a
// single pass instead of the four-pass path.
module system_cpu_0_mulx_seq
  import system_cpu_0_mul_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result
);

  localparam logic [1:0] DRAIN_LAST = 2'(CELL_LATENCY - 1);

  mul_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        accept;
  logic        issue_vld;
  logic [1:0]  issue_idx;
  logic        tag_vld_q [CELL_LATENCY];
  logic [1:0]  tag_idx_q [CELL_LATENCY];
  logic        fast_path;

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign accept = start & ready;

`ifdef SYSTEM_CPU_0_MULX_FAST_MUL_EN
  assign fast_path = (op_q == MUL_OP_MUL);
`else
  assign fast_path = 1'b0;
`endif

  // State register and the shared issue/drain counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus cell operand drive for the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue_vld = 1'b0;
    issue_idx = '0;
    cell_src1 = '0;
    cell_src2 = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
`ifdef SYSTEM_CPU_0_MULX_FAST_MUL_EN
          state_d = (op == MUL_OP_MUL) ? ST_FAST : ST_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        issue_vld = 1'b1;
        issue_idx = cnt_q;
        cell_src1 = pp_half(a_q, cnt_q[0]);
        cell_src2 = pp_half(b_q, cnt_q[1]);
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
`ifdef SYSTEM_CPU_0_MULX_FAST_MUL_EN
      ST_FAST: begin
        // Whole operands in one pass; the tag index 0 adds it unshifted.
        issue_vld = 1'b1;
        cell_src1 = a_q;
        cell_src2 = b_q;
        cnt_d     = '0;
        state_d   = ST_DRAIN;
      end
`endif
      ST_DRAIN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = fast_path ? ST_DONE : ST_CORRECT;
        end
      end
      ST_CORRECT: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operand and op capture on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= src_a;
      b_q  <= src_b;
    end
  end

  // Valid/index tags track each issued product through the cell latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CELL_LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue_vld;
      tag_idx_q[0] <= issue_idx;
      for (int unsigned i = 1; i < CELL_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  system_cpu_0_mulx_acc u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (accept),
    .add       (tag_vld_q[CELL_LATENCY-1]),
    .add_idx   (tag_idx_q[CELL_LATENCY-1]),
    .add_value (cell_result),
    .correct   (state_q == ST_CORRECT),
    .op        (op_q),
    .opa       (a_q),
    .opb       (b_q),
    .load      (done),
    .result    (result)
  );

endmodule
